ahb_fetch_master: RTL and testbench

AHB-Lite read-only master that fetches 32-bit instruction words from the memory slave and buffers them for the core front end. It holds a fetch PC and issues single-word NONSEQ reads, honouring slave wait states and error responses. Returned words go into a small FIFO that the decode stage pops through a valid/ready handshake. A redirect input (branch or jump) flushes the FIFO and restarts fetching at a new PC.

---
 rtl/ahb_pkg.sv | 33 +++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/ahb_fetch_master.sv | 143 ++++++++++++++
 tb/tb_ahb_fetch_master.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and fetch-master state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    HALT
  } fetch_state_t;

  // Canonical no-operation instruction word
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Clear the byte-offset bits so the address is word aligned
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: small synchronous FIFO with a registered head entry.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so push+pop is allowed when full
  always_comb begin
    do_pop  = pop && head_valid;
    do_push = push && ((count < CW'(DEPTH)) || do_pop);
    rd_nxt  = rd_ptr + AW'(1);
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and registered head; flush wins over push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      count <= count + CW'(do_push) - CW'(do_pop);
      if (do_pop) begin
        head_valid <= (count > CW'(1)) || do_push;
        if (count > CW'(1)) head_data <= mem[rd_nxt];
        else if (do_push)   head_data <= din;
      end else if (!head_valid && do_push) begin
        head_valid <= 1'b1;
        head_data  <= din;
      end
    end
  end

endmodule

// File: rtl/ahb_fetch_master.sv
// AHB-Lite read-only instruction fetch master with a decode-side buffer.
module ahb_fetch_master
  import ahb_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  output logic        HSEL,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        bus_error
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state;
  htrans_t       htrans_q;
  logic [31:0]   pc;
  logic [31:0]   haddr_q;
  logic [31:0]   xfer_pc;
  logic          hsel_q;
  logic          drop;
  logic          bus_err_q;

  logic [CW-1:0] count;
  logic [CW-1:0] cnt_after;
  logic          push;
  logic          pop;
  logic          issue_ok;
  logic [31:0]   pc_n;
  logic [63:0]   head;

  // Push/pop qualification and the issue check against next-cycle occupancy
  always_comb begin
    push      = (state == DATA) && HREADY && (HRESP != HRESP_ERROR) && !drop && !redirect_valid;
    pop       = instr_valid && instr_ready && !redirect_valid;
    pc_n      = redirect_valid ? word_align(redirect_pc) : pc;
    cnt_after = redirect_valid ? '0 : (count + CW'(push) - CW'(pop));
    issue_ok  = fetch_en && !bus_err_q && (cnt_after < CW'(FIFO_DEPTH));
  end

  // Bus FSM: one outstanding single-word read, registered AHB outputs
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      haddr_q   <= RESET_PC;
      htrans_q  <= TRANS_IDLE;
      hsel_q    <= 1'b0;
      drop      <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      pc <= pc_n;
      case (state)
        IDLE: begin
          if (issue_ok) begin
            state    <= ADDR;
            htrans_q <= TRANS_NONSEQ;
            hsel_q   <= 1'b1;
            haddr_q  <= pc_n;
          end
        end
        ADDR: begin
          // Address stays put until accepted; a redirect only marks the data for discard
          if (redirect_valid) drop <= 1'b1;
          if (HREADY) begin
            state    <= DATA;
            htrans_q <= TRANS_IDLE;
            hsel_q   <= 1'b0;
            xfer_pc  <= haddr_q;
            if (!redirect_valid && !drop) pc <= pc + 32'd4;
          end
        end
        DATA: begin
          if (HREADY) begin
            drop <= 1'b0;
            if (HRESP == HRESP_ERROR) begin
              bus_err_q <= 1'b1;
              state     <= HALT;
            end else if (issue_ok) begin
              state    <= ADDR;
              htrans_q <= TRANS_NONSEQ;
              hsel_q   <= 1'b1;
              haddr_q  <= pc_n;
            end else begin
              state <= IDLE;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        HALT: begin
          if (redirect_valid) begin
            bus_err_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk        (HCLK),
    .rst        (HRESET),
    .push       (push),
    .din        ({xfer_pc, HRDATA}),
    .pop        (instr_valid && instr_ready),
    .flush      (redirect_valid),
    .head_valid (instr_valid),
    .head_data  (head),
    .count      (count)
  );

  assign HADDR      = haddr_q;
  assign HTRANS     = htrans_q;
  assign HSEL       = hsel_q;
  assign HWRITE     = 1'b0;
  assign HSIZE      = HSIZE_WORD;
  assign HWDATA     = '0;
  assign bus_error  = bus_err_q;
  assign instr_pc   = head[63:32];
  assign instr_data = head[31:0];

endmodule

// File: tb/tb_ahb_fetch_master.sv
// Bench for ahb_fetch_master: AHB slave model plus expected-PC scoreboard.
module tb_ahb_fetch_master;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HSEL;
  logic [31:0] HRDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic [1:0]  HRESP  = 2'b00;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        bus_error;

  always #5 HCLK = ~HCLK;

  ahb_fetch_master #(.FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HSEL(HSEL), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .bus_error(bus_error)
  );

  // Memory contents seen by the slave
  function automatic logic [31:0] memfun(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'hC:   return 32'h44;
      default: return 32'hA500_0000 ^ a;
    endcase
  endfunction

  // Slave knobs (set by the stimulus process)
  int          lat;
  logic [31:0] err_addr;
  bit          stall_en;

  // Slave-private state
  int          wcnt;
  int          mode;
  logic [31:0] saddr;
  bit          stalled_once;

  // AHB slave: wait states, two-cycle ERROR, one optional idle stall
  always @(posedge HCLK) begin
    if (HRESET) begin
      HREADY       <= 1'b1;
      HRESP        <= 2'b00;
      HRDATA       <= 32'h0;
      mode         <= 0;
      wcnt         <= 0;
      stalled_once <= 1'b0;
    end else if (HREADY) begin
      if (HTRANS == T_NSEQ && HSEL) begin
        if (HADDR == err_addr) begin
          HREADY <= 1'b0; HRESP <= 2'b01; mode <= 2;
        end else if (lat == 0) begin
          HREADY <= 1'b1; HRESP <= 2'b00; HRDATA <= memfun(HADDR);
        end else begin
          HREADY <= 1'b0; HRESP <= 2'b00; mode <= 1; wcnt <= lat; saddr <= HADDR;
        end
      end else if (stall_en && !stalled_once) begin
        HREADY <= 1'b0; HRESP <= 2'b00; mode <= 0; wcnt <= 2; stalled_once <= 1'b1;
      end else begin
        HREADY <= 1'b1; HRESP <= 2'b00;
      end
    end else begin
      if (mode == 2) HREADY <= 1'b1;
      else if (wcnt == 1) begin
        HREADY <= 1'b1;
        if (mode == 1) HRDATA <= memfun(saddr);
      end else wcnt <= wcnt - 1;
    end
  end

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          pops, holds, errc, c0, k;
  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];
  int          pop_cyc[$];
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] tmp;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle observation at the falling edge: scoreboard pops and bus rules
  task automatic monitor();
    logic [31:0] e;
    if (HRESET) begin
      prev_wait = 1'b0;
      return;
    end
    if (instr_valid && instr_ready && !redirect_valid) begin
      e = 32'hDEAD_BEEF;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check_eq("sb_pc", instr_pc, e);
      check_eq("sb_data", instr_data, memfun(e));
      pops++;
      pop_cyc.push_back(cyc);
    end
    if (HTRANS == T_NSEQ && HREADY) acc_q.push_back(HADDR);
    if (prev_wait) begin
      check_eq("hold_trans", HTRANS, T_NSEQ);
      check_eq("hold_addr", HADDR, prev_addr);
      holds++;
    end
    prev_wait = (HTRANS == T_NSEQ) && !HREADY;
    prev_addr = HADDR;
    if (HRESP == 2'b01 && !HREADY) begin
      check_eq("err_htrans", HTRANS, T_IDLE);
      errc++;
    end
    check_eq("hsel", HSEL, HTRANS == T_NSEQ);
  endtask

  task automatic cycle();
    @(negedge HCLK);
    monitor();
    @(posedge HCLK);
    cyc++;
    #1;
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic do_reset();
    HRESET = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
    cycle();
    cycle();
    exp_q.delete(); acc_q.delete(); pop_cyc.delete();
    pops = 0; holds = 0; errc = 0;
  endtask

  task automatic run_until_pops(input string tag, input int n, input int budget);
    int j = 0;
    while (pops < n && j < budget) begin
      cycle();
      j++;
    end
    check_eq(tag, pops >= n, 1'b1);
  endtask

  task automatic wait_acc(input string tag, input int n, input int budget);
    int j = 0;
    while (acc_q.size() < n && j < budget) begin
      cycle();
      j++;
    end
    check_eq(tag, acc_q.size(), n);
  endtask

  initial begin
    HRESET = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    instr_ready = 1'b1; lat = 0; err_addr = 32'hFFFF_FFFF; stall_en = 1'b0;
    pops = 0; holds = 0; errc = 0; c0 = 0; k = 0;

    // Reset values and zero-wait streaming
    do_reset();
    check_eq("rst_htrans", HTRANS, T_IDLE);
    check_eq("rst_hsel", HSEL, 1'b0);
    check_eq("rst_haddr", HADDR, 32'h0);
    check_eq("rst_valid", instr_valid, 1'b0);
    check_eq("rst_data", instr_data, 32'h0);
    check_eq("rst_pc", instr_pc, 32'h0);
    check_eq("rst_buserr", bus_error, 1'b0);
    check_eq("hwrite", HWRITE, 1'b0);
    check_eq("hsize", HSIZE, 3'b010);
    check_eq("hwdata", HWDATA, 32'h0);
    push_stream(32'h0, 16);
    HRESET = 1'b0; fetch_en = 1'b1; c0 = cyc;
    run_until_pops("t1_pops", 4, 40);
    if (pop_cyc.size() >= 4) begin
      check_eq("t1_first_lat", pop_cyc[0] - c0, 3);
      check_eq("t1_gap1", pop_cyc[1] - pop_cyc[0], 2);
      check_eq("t1_gap2", pop_cyc[2] - pop_cyc[1], 2);
      check_eq("t1_gap3", pop_cyc[3] - pop_cyc[2], 2);
    end

    // Two wait states plus an address-phase stall
    do_reset();
    lat = 2; stall_en = 1'b1;
    push_stream(32'h0, 16);
    HRESET = 1'b0; fetch_en = 1'b1;
    run_until_pops("t2_pops", 3, 60);
    check_eq("t2_holds", holds, 2);
    if (pop_cyc.size() >= 3) begin
      check_eq("t2_gap1", pop_cyc[1] - pop_cyc[0], 4);
      check_eq("t2_gap2", pop_cyc[2] - pop_cyc[1], 4);
    end
    stall_en = 1'b0;

    // Consumer stalled: buffer fills, bus goes quiet, then resumes at 0x10
    do_reset();
    lat = 0; instr_ready = 1'b0;
    push_stream(32'h0, 16);
    HRESET = 1'b0; fetch_en = 1'b1;
    repeat (30) cycle();
    check_eq("t3_issued", acc_q.size(), 4);
    check_eq("t3_idle", HTRANS, T_IDLE);
    check_eq("t3_valid", instr_valid, 1'b1);
    check_eq("t3_head_pc", instr_pc, 32'h0);
    check_eq("t3_head_data", instr_data, 32'h11);
    instr_ready = 1'b1;
    run_until_pops("t3_pops", 6, 60);
    tmp = 32'hDEAD_BEEF;
    if (acc_q.size() > 4) tmp = acc_q[4];
    check_eq("t3_resume_addr", tmp, 32'h10);

    // Redirect during a data phase with two words buffered
    do_reset();
    lat = 2; instr_ready = 1'b0;
    push_stream(32'h0, 16);
    HRESET = 1'b0; fetch_en = 1'b1;
    wait_acc("t4_third_issue", 3, 60);
    check_eq("t4_pre_valid", instr_valid, 1'b1);
    check_eq("t4_pre_pc", instr_pc, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h43; instr_ready = 1'b1;
    exp_q.delete(); acc_q.delete(); push_stream(32'h40, 16); pops = 0;
    cycle();
    redirect_valid = 1'b0;
    check_eq("t4_flush", instr_valid, 1'b0);
    run_until_pops("t4_pops", 3, 80);
    tmp = 32'hDEAD_BEEF;
    if (acc_q.size() > 0) tmp = acc_q[0];
    check_eq("t4_new_addr", tmp, 32'h40);

    // ERROR response at 0x8, then recovery by redirect
    do_reset();
    lat = 0; err_addr = 32'h8; instr_ready = 1'b1;
    push_stream(32'h0, 2);
    HRESET = 1'b0; fetch_en = 1'b1;
    repeat (20) cycle();
    check_eq("t5_buserr", bus_error, 1'b1);
    check_eq("t5_pops", pops, 2);
    check_eq("t5_issued", acc_q.size(), 3);
    check_eq("t5_err_cycles", errc, 1);
    check_eq("t5_quiet", HTRANS, T_IDLE);
    err_addr = 32'hFFFF_FFFF;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    exp_q.delete(); push_stream(32'h0, 16); pops = 0;
    cycle();
    redirect_valid = 1'b0;
    check_eq("t5_buserr_clr", bus_error, 1'b0);
    run_until_pops("t5_resume", 3, 40);

    // Reset in the middle of a data phase with three words buffered
    do_reset();
    lat = 2; instr_ready = 1'b0;
    push_stream(32'h0, 16);
    HRESET = 1'b0; fetch_en = 1'b1;
    wait_acc("t6_fourth_issue", 4, 80);
    check_eq("t6_pre_valid", instr_valid, 1'b1);
    check_eq("t6_pre_pc", instr_pc, 32'h0);
    HRESET = 1'b1;
    cycle();
    check_eq("t6_valid", instr_valid, 1'b0);
    check_eq("t6_htrans", HTRANS, T_IDLE);
    check_eq("t6_haddr", HADDR, 32'h0);
    HRESET = 1'b0; instr_ready = 1'b1;
    exp_q.delete(); acc_q.delete(); push_stream(32'h0, 16); pops = 0;
    cycle();
    check_eq("t6_restart_trans", HTRANS, T_NSEQ);
    check_eq("t6_restart_addr", HADDR, 32'h0);
    run_until_pops("t6_pops", 2, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
